// File: rtl/lsu_ctrl.sv
// Memory-stage load/store sequencer: one decoded access -> one valid/ready bus
// transaction, with strobe/data alignment, load extension and misalign abort.
module lsu_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_ena,
  input  logic        mem_w_ena,
  input  logic [7:0]  byte_enable,
  input  logic        mem_ext_un,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [63:0] rdata,
  output logic        misalign,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic [63:0] bus_addr,
  output logic [7:0]  bus_wstrb,
  output logic [63:0] bus_wdata,
  input  logic        bus_rvalid,
  input  logic [63:0] bus_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t      state, state_nx;
  logic        req, legal, aligned;
  logic [1:0]  sz, sz_q;   // log2 of access size in bytes
  logic        ext_q;
  logic [2:0]  off_q;
  logic [63:0] shifted, load_val;

  assign req = mem_r_ena | mem_w_ena;

  always_comb begin
    legal = 1'b1;
    sz    = 2'd0;
    case (byte_enable)
      8'h01:   sz = 2'd0;
      8'h03:   sz = 2'd1;
      8'h0F:   sz = 2'd2;
      8'hFF:   sz = 2'd3;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    aligned = 1'b1;
    case (sz)
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = ~addr[0];
      2'd2:    aligned = (addr[1:0] == 2'b00);
      default: aligned = (addr[2:0] == 3'b000);
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req) state_nx = (legal && aligned) ? REQ : DONE;
      REQ:     if (bus_ready) state_nx = RESP;
      RESP:    if (bus_rvalid) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  assign bus_valid = (state == REQ);
  assign done      = (state == DONE);
  assign stall     = ((state == IDLE) && req) || (state == REQ) || (state == RESP);

  // Bring the addressed lane down to bit 0, then extend from the access size.
  assign shifted = bus_rdata >> {off_q, 3'b000};

  always_comb begin
    load_val = shifted;
    case (sz_q)
      2'd0:    load_val = {{56{~ext_q & shifted[7]}},  shifted[7:0]};
      2'd1:    load_val = {{48{~ext_q & shifted[15]}}, shifted[15:0]};
      2'd2:    load_val = {{32{~ext_q & shifted[31]}}, shifted[31:0]};
      default: load_val = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wstrb <= '0;
      bus_wdata <= '0;
      sz_q      <= '0;
      ext_q     <= 1'b0;
      off_q     <= '0;
      rdata     <= '0;
      misalign  <= 1'b0;
    end else begin
      if ((state == IDLE) && req) begin
        if (legal && aligned) begin
          bus_we    <= mem_w_ena;
          bus_addr  <= {addr[63:3], 3'b000};
          bus_wstrb <= byte_enable << addr[2:0];
          bus_wdata <= wdata << {addr[2:0], 3'b000};
          sz_q      <= sz;
          ext_q     <= mem_ext_un;
          off_q     <= addr[2:0];
        end else begin
          misalign  <= 1'b1;
          rdata     <= '0;
        end
      end
      if ((state == RESP) && bus_rvalid) begin
        misalign <= 1'b0;
        rdata    <= bus_we ? '0 : load_val;
      end
    end
  end
endmodule
